// File: rtl/rom_arbiter_if.sv
// Bundles the requester handshakes (IF and MEM) and the ROM-side control/data
// for the ROM arbiter. The arbiter uses the slave view; the environment
// (requesters plus ROM) uses the master view.
interface rom_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Instruction-fetch requester
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_data_o;
    logic              if_err_o;

    // Data/memory requester
    logic              mem_req_i;
    logic              mem_we_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic              mem_ack_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_err_o;

    // Single-port synchronous ROM
    logic              rom_ce_o;
    logic              rom_we_o;
    logic [ADDR_W-1:0] rom_addr_o;
    logic [DATA_W-1:0] rom_data_i;
    logic              rom_ready_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  mem_req_i, mem_we_i, mem_addr_i,
        input  rom_data_i, rom_ready_i,
        output if_ack_o, if_data_o, if_err_o,
        output mem_ack_o, mem_data_o, mem_err_o,
        output rom_ce_o, rom_we_o, rom_addr_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output mem_req_i, mem_we_i, mem_addr_i,
        output rom_data_i, rom_ready_i,
        input  if_ack_o, if_data_o, if_err_o,
        input  mem_ack_o, mem_data_o, mem_err_o,
        input  rom_ce_o, rom_we_o, rom_addr_o
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-requester arbiter and sequencer for a single-port synchronous ROM.
// MEM has priority, but IF is forced through after MEM_STREAK_MAX consecutive
// MEM grants while IF waits. Misaligned and timed-out accesses complete with
// err set. All outputs are registered.
module rom_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MEM_STREAK_MAX = 4,
    parameter int TIMEOUT        = 8
) (
    input  logic         clk,
    input  logic         rst,
    rom_arbiter_if.slave bus
);
    localparam int SK_W = $clog2(MEM_STREAK_MAX + 1);
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SK_W-1:0] SK_MAX  = SK_W'(MEM_STREAK_MAX);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [SK_W-1:0]   streak, streak_nxt;
    logic [TO_W-1:0]   tcnt, tcnt_nxt;
    logic              win_mem, win_mem_nxt;   // winner latched at grant
    logic              win_we, win_we_nxt;     // write flag latched at grant

    logic              rom_ce_q, rom_ce_nxt;
    logic              rom_we_q, rom_we_nxt;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_nxt;
    logic              if_ack_q, if_ack_nxt;
    logic              if_err_q, if_err_nxt;
    logic [DATA_W-1:0] if_data_q, if_data_nxt;
    logic              mem_ack_q, mem_ack_nxt;
    logic              mem_err_q, mem_err_nxt;
    logic [DATA_W-1:0] mem_data_q, mem_data_nxt;

    logic              grant;
    logic              pick_mem;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] rd_data;

    // Next-state, counters and registered-output values
    always_comb begin
        state_nxt    = state;
        streak_nxt   = streak;
        tcnt_nxt     = '0;
        win_mem_nxt  = win_mem;
        win_we_nxt   = win_we;
        rom_ce_nxt   = 1'b0;
        rom_we_nxt   = 1'b0;
        rom_addr_nxt = '0;
        if_ack_nxt   = 1'b0;
        if_err_nxt   = 1'b0;
        if_data_nxt  = '0;
        mem_ack_nxt  = 1'b0;
        mem_err_nxt  = 1'b0;
        mem_data_nxt = '0;
        grant        = 1'b0;
        pick_mem     = 1'b0;
        pick_addr    = '0;
        rd_data      = win_we ? '0 : bus.rom_data_i;

        case (state)
            IDLE: begin
                if (bus.mem_req_i && !(bus.if_req_i && streak == SK_MAX)) begin
                    grant    = 1'b1;
                    pick_mem = 1'b1;
                end else if (bus.if_req_i) begin
                    grant    = 1'b1;
                    pick_mem = 1'b0;
                end
                pick_addr = pick_mem ? bus.mem_addr_i : bus.if_addr_i;

                if (grant) begin
                    win_mem_nxt = pick_mem;
                    win_we_nxt  = pick_mem & bus.mem_we_i;
                    // Streak only grows while IF is actually being held off
                    if (pick_mem && bus.if_req_i)
                        streak_nxt = (streak < SK_MAX) ? streak + SK_W'(1) : streak;
                    else
                        streak_nxt = '0;

                    if (pick_addr[1:0] != 2'b00) begin
                        // Misaligned: complete with error, ROM untouched
                        state_nxt   = RESP;
                        if_ack_nxt  = ~pick_mem;
                        if_err_nxt  = ~pick_mem;
                        mem_ack_nxt = pick_mem;
                        mem_err_nxt = pick_mem;
                    end else begin
                        state_nxt    = ISSUE;
                        rom_ce_nxt   = 1'b1;
                        rom_we_nxt   = pick_mem & bus.mem_we_i;
                        rom_addr_nxt = pick_addr;
                    end
                end
            end

            ISSUE: begin
                state_nxt = WAIT;
            end

            WAIT: begin
                if (bus.rom_ready_i) begin
                    state_nxt = RESP;
                    if (win_mem) begin
                        mem_ack_nxt  = 1'b1;
                        mem_data_nxt = rd_data;
                    end else begin
                        if_ack_nxt  = 1'b1;
                        if_data_nxt = rd_data;
                    end
                end else if (tcnt == TO_LAST) begin
                    state_nxt   = RESP;
                    if_ack_nxt  = ~win_mem;
                    if_err_nxt  = ~win_mem;
                    mem_ack_nxt = win_mem;
                    mem_err_nxt = win_mem;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end

            RESP: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, counters and output registers; reset discards any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            streak     <= '0;
            tcnt       <= '0;
            win_mem    <= 1'b0;
            win_we     <= 1'b0;
            rom_ce_q   <= 1'b0;
            rom_we_q   <= 1'b0;
            rom_addr_q <= '0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_data_q  <= '0;
            mem_ack_q  <= 1'b0;
            mem_err_q  <= 1'b0;
            mem_data_q <= '0;
        end else begin
            state      <= state_nxt;
            streak     <= streak_nxt;
            tcnt       <= tcnt_nxt;
            win_mem    <= win_mem_nxt;
            win_we     <= win_we_nxt;
            rom_ce_q   <= rom_ce_nxt;
            rom_we_q   <= rom_we_nxt;
            rom_addr_q <= rom_addr_nxt;
            if_ack_q   <= if_ack_nxt;
            if_err_q   <= if_err_nxt;
            if_data_q  <= if_data_nxt;
            mem_ack_q  <= mem_ack_nxt;
            mem_err_q  <= mem_err_nxt;
            mem_data_q <= mem_data_nxt;
        end
    end

    assign bus.rom_ce_o   = rom_ce_q;
    assign bus.rom_we_o   = rom_we_q;
    assign bus.rom_addr_o = rom_addr_q;
    assign bus.if_ack_o   = if_ack_q;
    assign bus.if_err_o   = if_err_q;
    assign bus.if_data_o  = if_data_q;
    assign bus.mem_ack_o  = mem_ack_q;
    assign bus.mem_err_o  = mem_err_q;
    assign bus.mem_data_o = mem_data_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Testbench for rom_arbiter: directed requests, a registered ROM model and a
// completion scoreboard checked whenever an ack appears.
module tb_rom_arbiter;
    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int MEM_STREAK_MAX = 4;
    localparam int TIMEOUT        = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .MEM_STREAK_MAX(MEM_STREAK_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit          is_mem;
        bit          err;
        logic [31:0] data;
        int          exp_cyc;   // negative: cycle not checked
    } exp_t;

    exp_t        sb[$];
    int          ack_log[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          ce_cnt = 0;
    logic [31:0] ce_addr = '0;
    logic        ce_we = 1'b0;
    logic [31:0] rom_mem [0:63];
    logic        rom_ready_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_mem, input bit err, input logic [31:0] data, input int exp_cyc);
        exp_t e;
        e.is_mem  = is_mem;
        e.err     = err;
        e.data    = data;
        e.exp_cyc = exp_cyc;
        sb.push_back(e);
    endtask

    // Waits for n acks (bounded), then releases all requests
    task automatic wait_acks(input int n, input int budget, input string tag);
        int seen = 0;
        int k = 0;
        while (seen < n && k < budget) begin
            @(negedge clk);
            k++;
            if (bus.if_ack_o || bus.mem_ack_o) seen++;
        end
        bus.if_req_i  = 1'b0;
        bus.mem_req_i = 1'b0;
        bus.mem_we_i  = 1'b0;
        if (seen < n) begin
            checks++;
            errors++;
            $error("FAIL %s_ack_wait: observed %0d acks expected %0d", tag, seen, n);
        end
        @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Registered ROM: data and ready appear the cycle after ce is sampled
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rom_ready_i <= 1'b0;
            bus.rom_data_i  <= '0;
        end else begin
            bus.rom_ready_i <= bus.rom_ce_o & rom_ready_en;
            if (bus.rom_ce_o)
                bus.rom_data_i <= bus.rom_we_o ? 32'hDEAD_BEEF : rom_mem[bus.rom_addr_o[7:2]];
        end
    end

    // Monitor: ROM accesses and completions against the scoreboard
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.rom_ce_o) begin
                ce_cnt++;
                ce_addr = bus.rom_addr_o;
                ce_we   = bus.rom_we_o;
            end
            if (bus.if_ack_o || bus.mem_ack_o) begin
                ack_log.push_back(cyc);
                chk("ack_exclusive", 64'(bus.if_ack_o & bus.mem_ack_o), 64'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_ack: observed if_ack=%0b mem_ack=%0b expected no ack",
                           bus.if_ack_o, bus.mem_ack_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_is_mem", 64'(bus.mem_ack_o), 64'(mon_e.is_mem));
                    chk("ack_err", 64'(mon_e.is_mem ? bus.mem_err_o : bus.if_err_o), 64'(mon_e.err));
                    chk("ack_data", 64'(mon_e.is_mem ? bus.mem_data_o : bus.if_data_o), 64'(mon_e.data));
                    if (mon_e.exp_cyc >= 0)
                        chk("ack_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) rom_mem[i] = 32'h1000_0000 | (i << 2);
        rom_mem[4] = 32'h3C01_8000;
        rst            = 1'b0;
        rom_ready_en   = 1'b1;
        bus.if_req_i   = 1'b0;
        bus.if_addr_i  = '0;
        bus.mem_req_i  = 1'b0;
        bus.mem_we_i   = 1'b0;
        bus.mem_addr_i = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("reset_ctrl", 64'({bus.if_ack_o, bus.if_err_o, bus.mem_ack_o, bus.mem_err_o,
                               bus.rom_ce_o, bus.rom_we_o}), 64'd0);
        chk("reset_data", 64'(bus.if_data_o | bus.mem_data_o | bus.rom_addr_o), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // IF only, word 4
        ce_cnt = 0;
        push(1'b0, 1'b0, 32'h3C01_8000, cyc + 3);
        bus.if_addr_i = 32'h10;
        bus.if_req_i  = 1'b1;
        wait_acks(1, 20, "if_only");
        chk("if_only_ce_cycles", 64'(ce_cnt), 64'd1);
        chk("if_only_ce_addr", 64'(ce_addr), 64'h10);
        chk("if_only_ce_we", 64'(ce_we), 64'd0);

        // Both requesters held: M,M,M,M,I,M,M,M,M,I
        ack_log.delete();
        bus.mem_addr_i = 32'h8;
        bus.if_addr_i  = 32'h10;
        for (int g = 0; g < 10; g++) begin
            if ((g % 5) != 4) push(1'b1, 1'b0, 32'h1000_0008, (g == 0) ? cyc + 3 : -1);
            else              push(1'b0, 1'b0, 32'h3C01_8000, -1);
        end
        bus.mem_req_i = 1'b1;
        bus.if_req_i  = 1'b1;
        wait_acks(10, 80, "contention");
        chk("contention_ack_count", 64'(ack_log.size()), 64'd10);
        for (int i = 0; i + 1 < ack_log.size(); i++)
            chk("contention_ack_spacing", 64'(ack_log[i+1] - ack_log[i]), 64'd4);

        // Misaligned MEM read
        ce_cnt = 0;
        push(1'b1, 1'b1, 32'h0, cyc + 1);
        bus.mem_addr_i = 32'h6;
        bus.mem_req_i  = 1'b1;
        wait_acks(1, 20, "misaligned");
        chk("misaligned_no_rom_access", 64'(ce_cnt), 64'd0);

        // ROM never ready: timeout after TIMEOUT wait cycles, then a normal access
        rom_ready_en = 1'b0;
        push(1'b0, 1'b1, 32'h0, cyc + 2 + TIMEOUT);
        bus.if_addr_i = 32'h20;
        bus.if_req_i  = 1'b1;
        wait_acks(1, 30, "timeout");
        rom_ready_en = 1'b1;
        push(1'b0, 1'b0, 32'h1000_0020, cyc + 3);
        bus.if_req_i = 1'b1;
        wait_acks(1, 20, "after_timeout");

        // MEM write
        ce_cnt = 0;
        push(1'b1, 1'b0, 32'h0, cyc + 3);
        bus.mem_addr_i = 32'h40;
        bus.mem_we_i   = 1'b1;
        bus.mem_req_i  = 1'b1;
        wait_acks(1, 20, "write");
        chk("write_ce_cycles", 64'(ce_cnt), 64'd1);
        chk("write_rom_we", 64'(ce_we), 64'd1);
        chk("write_rom_addr", 64'(ce_addr), 64'h40);

        // Asynchronous reset in the middle of WAIT
        rom_ready_en  = 1'b0;
        bus.if_addr_i = 32'h10;
        bus.if_req_i  = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_ctrl", 64'({bus.if_ack_o, bus.if_err_o, bus.mem_ack_o, bus.mem_err_o,
                                     bus.rom_ce_o, bus.rom_we_o}), 64'd0);
        chk("async_reset_data", 64'(bus.if_data_o | bus.mem_data_o | bus.rom_addr_o), 64'd0);
        bus.if_req_i = 1'b0;
        rst          = 1'b1;
        rom_ready_en = 1'b1;
        ce_cnt       = 0;
        repeat (15) @(negedge clk);
        chk("after_reset_no_rom_access", 64'(ce_cnt), 64'd0);
        push(1'b0, 1'b0, 32'h3C01_8000, cyc + 3);
        bus.if_req_i = 1'b1;
        wait_acks(1, 20, "after_reset");

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
